// File: rtl/spike_accumulator_pkg.sv
// Shared types and saturating-arithmetic helpers for the presynaptic accumulator.
// Bound and add helpers work on 64-bit sign-extended containers so any WIDTH up to 64 can use them.
package spike_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } accum_state_t;

  localparam int MAX_W  = 64;
  localparam int MAX_IW = $clog2(MAX_W);

  function automatic logic [MAX_W-1:0] sat_pos(input int w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] sat_neg(input int w);
    return ~sat_pos(w);
  endfunction

  function automatic logic bit_at(input logic [MAX_W-1:0] v, input int n);
    return v[MAX_IW'(n)];
  endfunction

  // Returns {overflow, clamped sum}; overflow means equal operand signs with a flipped result sign.
  function automatic logic [MAX_W:0] sat_add(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input int w);
    logic [MAX_W-1:0] s;
    logic             ovf;
    s   = a + b;
    ovf = (bit_at(a, w - 1) == bit_at(b, w - 1)) && (bit_at(s, w - 1) != bit_at(a, w - 1));
    if (ovf) s = bit_at(a, w - 1) ? sat_neg(w) : sat_pos(w);
    return {ovf, s};
  endfunction

endpackage

// File: rtl/spike_accumulator_if.sv
// Control and weight-BRAM bundle between a controller (master) and the accumulator (slave).
// start is a level request taken only in IDLE/DONE; done is a level held until the next taken start.
interface spike_accumulator_if #(
  parameter int N_PRE      = 16,
  parameter int WIDTH      = 32,
  parameter int W_WIDTH    = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int POST_WIDTH = 8
);
  logic                  start;
  logic [N_PRE-1:0]      spk_vec;
  logic [POST_WIDTH-1:0] post_idx;
  logic                  w_rd_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [W_WIDTH-1:0]    w_data;
  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      network_input;
  logic                  sat;

  modport slave (
    input  start, spk_vec, post_idx, w_data,
    output w_rd_en, w_addr, busy, done, network_input, sat
  );

  modport master (
    output start, spk_vec, post_idx, w_data,
    input  w_rd_en, w_addr, busy, done, network_input, sat
  );
endinterface

// File: rtl/spike_accumulator_sat_adder.sv
// Combinational WIDTH-bit signed saturating adder with an overflow flag.
module spike_accumulator_sat_adder
  import spike_accumulator_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             ovf_o
);
  logic [MAX_W:0] res;

  always_comb begin
    res   = sat_add(MAX_W'($signed(a_i)), MAX_W'($signed(b_i)), WIDTH);
    sum_o = res[WIDTH-1:0];
    ovf_o = res[MAX_W];
  end
endmodule

// File: rtl/spike_accumulator.sv
// Scans a latched spike vector one bit per cycle, reads each active synapse weight
// (1-cycle BRAM latency) and accumulates a saturating signed sum for the neuron.
module spike_accumulator
  import spike_accumulator_pkg::*;
#(
  parameter int N_PRE      = 16,
  parameter int WIDTH      = 32,
  parameter int W_WIDTH    = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int POST_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  spike_accumulator_if.slave  bus,
  output accum_state_t        dbg_state_o
);
  localparam int IDX_W = (N_PRE > 1) ? $clog2(N_PRE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PRE - 1);

  accum_state_t          state_q, state_d;
  logic [N_PRE-1:0]      spk_q, spk_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0]      sum_q, sum_d;
  logic                  sat_q, sat_d;
  logic [WIDTH-1:0]      add_sum;
  logic                  add_ovf;
  logic                  accept;

  assign accept      = bus.start && (state_q == IDLE || state_q == DONE);
  assign dbg_state_o = state_q;

  spike_accumulator_sat_adder #(.WIDTH(WIDTH)) u_add (
    .a_i   (sum_q),
    .b_i   (WIDTH'($signed(bus.w_data))),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SCAN;
      SCAN:    if (idx_q == LAST_IDX) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (accept) state_d = SCAN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy          = 1'b0;
    bus.done          = 1'b0;
    bus.w_rd_en       = 1'b0;
    bus.w_addr        = '0;
    bus.network_input = '0;
    bus.sat           = sat_q;
    case (state_q)
      SCAN: begin
        bus.busy    = 1'b1;
        bus.w_rd_en = spk_q[idx_q];
        bus.w_addr  = base_q + ADDR_WIDTH'(idx_q);
      end
      DRAIN: bus.busy = 1'b1;
      DONE: begin
        bus.done          = 1'b1;
        bus.network_input = sum_q;
      end
      default: ;
    endcase
  end

  // The base multiply happens once at start so the scan path only adds the index.
  always_comb begin
    spk_d      = spk_q;
    base_d     = base_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    sat_d      = sat_q;
    rd_valid_d = (state_q == SCAN) && spk_q[idx_q];
    if (accept) begin
      spk_d  = bus.spk_vec;
      base_d = ADDR_WIDTH'(ADDR_WIDTH'(bus.post_idx) * ADDR_WIDTH'(N_PRE));
      idx_d  = '0;
      sum_d  = '0;
      sat_d  = 1'b0;
    end else begin
      if (state_q == SCAN) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      if (rd_valid_q) begin
        sum_d = add_sum;
        sat_d = sat_q | add_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spk_q      <= '0;
      base_q     <= '0;
      idx_q      <= '0;
      rd_valid_q <= 1'b0;
      sum_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      spk_q      <= spk_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      rd_valid_q <= rd_valid_d;
      sum_q      <= sum_d;
      sat_q      <= sat_d;
    end
  end
endmodule

// File: tb/tb_spike_accumulator.sv
// Directed bench: a 32-bit accumulator over a random weight BRAM plus an 8-bit one for saturation.
module tb_spike_accumulator;
  import spike_accumulator_pkg::*;

  localparam int NP = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [11:0] addr_q[$];
  logic [32:0] exp_q[$];
  logic [7:0]  mem_a [0:4095];

  accum_state_t state_a, state_b;

  spike_accumulator_if #(.N_PRE(NP), .WIDTH(32), .W_WIDTH(8), .ADDR_WIDTH(12), .POST_WIDTH(8)) ifa ();
  spike_accumulator_if #(.N_PRE(NP), .WIDTH(8),  .W_WIDTH(8), .ADDR_WIDTH(12), .POST_WIDTH(8)) ifb ();

  spike_accumulator #(.N_PRE(NP), .WIDTH(32), .W_WIDTH(8), .ADDR_WIDTH(12), .POST_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave), .dbg_state_o(state_a));
  spike_accumulator #(.N_PRE(NP), .WIDTH(8), .W_WIDTH(8), .ADDR_WIDTH(12), .POST_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave), .dbg_state_o(state_b));

  // Weight BRAMs with one cycle of read latency.
  always @(posedge clk) if (ifa.w_rd_en) ifa.w_data <= mem_a[ifa.w_addr];
  always @(posedge clk) if (ifb.w_rd_en) ifb.w_data <= 8'h7F;

  task automatic chk(input logic [63:0] obs, input logic [63:0] expv, input string tag);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst && ifa.w_rd_en) begin
      if (addr_q.size() == 0) chk(64'(ifa.w_addr), 64'hDEAD, "unexpected_read");
      else                    chk(64'(ifa.w_addr), 64'(addr_q.pop_front()), "w_addr");
    end
  end

  task automatic model(input logic [15:0] vec, input logic [7:0] pidx,
                       output logic [31:0] s_o, output logic sat_o);
    longint s;
    s     = 0;
    sat_o = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (vec[i]) begin
        s = s + longint'($signed(mem_a[12'(int'(pidx) * NP + i)]));
        if (s > 64'sd2147483647)       begin s = 64'sd2147483647;  sat_o = 1'b1; end
        else if (s < -64'sd2147483648) begin s = -64'sd2147483648; sat_o = 1'b1; end
      end
    end
    s_o = 32'(s);
  endtask

  task automatic run_a(input logic [15:0] vec, input logic [7:0] pidx, input int inject_at,
                       input logic [15:0] inj_vec, input int abort_at, input string tag);
    logic [31:0] es;
    logic        esat;
    logic [32:0] e;
    model(vec, pidx, es, esat);
    @(negedge clk);
    for (int i = 0; i < NP; i++) if (vec[i]) addr_q.push_back(12'(int'(pidx) * NP + i));
    exp_q.push_back({esat, es});
    ifa.spk_vec  = vec;
    ifa.post_idx = pidx;
    ifa.start    = 1'b1;
    for (int k = 1; k <= NP + 2; k++) begin
      @(posedge clk);
      if (k == abort_at) begin
        #2 rst = 1'b0;
        #1;
        chk(64'(ifa.busy), 0, {tag, "_rst_busy"});
        chk(64'(ifa.done), 0, {tag, "_rst_done"});
        chk(64'(ifa.network_input), 0, {tag, "_rst_net"});
        chk(64'(ifa.w_rd_en), 0, {tag, "_rst_rden"});
        chk(64'(ifa.sat), 0, {tag, "_rst_sat"});
        chk(64'(state_a), 64'(IDLE), {tag, "_rst_state"});
        addr_q.delete();
        void'(exp_q.pop_back());
        ifa.start = 1'b0;
        return;
      end
      @(negedge clk);
      ifa.start = (k == inject_at);
      if (k == inject_at) begin
        ifa.spk_vec  = inj_vec;
        ifa.post_idx = pidx + 8'd1;
      end
      if (k == 1) begin
        chk(64'(ifa.busy), 1, {tag, "_busy_rise"});
        chk(64'(ifa.done), 0, {tag, "_done_drop"});
      end
      if (k == NP + 1) chk(64'(ifa.done), 0, {tag, "_done_early"});
      if (k == NP + 2) begin
        e = exp_q.pop_front();
        chk(64'(ifa.done), 1, {tag, "_done"});
        chk(64'(ifa.busy), 0, {tag, "_busy_fall"});
        chk(64'(ifa.network_input), 64'(e[31:0]), {tag, "_sum"});
        chk(64'(ifa.sat), 64'(e[32]), {tag, "_sat"});
        chk(64'(addr_q.size()), 0, {tag, "_reads_missing"});
      end
    end
    @(negedge clk);
    chk(64'(ifa.done), 1, {tag, "_done_hold"});
    chk(64'(ifa.network_input), 64'(es), {tag, "_sum_hold"});
  endtask

  initial begin
    ifa.start = 1'b0; ifa.spk_vec = '0; ifa.post_idx = '0;
    ifb.start = 1'b0; ifb.spk_vec = '0; ifb.post_idx = '0;
    for (int a = 0; a < 4096; a++) mem_a[a] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 8; k++) begin
      mem_a[2 * k]     = 8'(k + 1);
      mem_a[2 * k + 1] = 8'(-(k + 1));
    end
    mem_a[19] = 8'hFB;

    #3;
    chk(64'(ifa.busy), 0, "reset_busy");
    chk(64'(ifa.done), 0, "reset_done");
    chk(64'(ifa.w_rd_en), 0, "reset_rden");
    chk(64'(ifa.w_addr), 0, "reset_addr");
    chk(64'(ifa.network_input), 0, "reset_net");
    chk(64'(ifa.sat), 0, "reset_sat");
    chk(64'(state_a), 64'(IDLE), "reset_state");
    @(negedge clk);
    rst = 1'b1;

    run_a(16'h0000, 8'd2, 0, 16'h0, 0, "t1_empty");
    run_a(16'h0008, 8'd1, 0, 16'h0, 0, "t2_single");
    chk(64'(ifa.network_input), 64'h0000_0000_FFFF_FFFB, "t2_minus5");
    run_a(16'hFFFF, 8'd0, 0, 16'h0, 0, "t3_alt");
    chk(64'(ifa.network_input), 0, "t3_zero");

    // 8-bit sum of sixteen +127 weights clamps on the second add and stays there.
    @(negedge clk);
    ifb.spk_vec = 16'hFFFF; ifb.post_idx = 8'd0; ifb.start = 1'b1;
    for (int k = 1; k <= NP + 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      ifb.start = 1'b0;
      if (k == 3) chk(64'(ifb.sat), 0, "t4_sat_first_add");
      if (k == 4) chk(64'(ifb.sat), 1, "t4_sat_second_add");
      if (k == NP + 1) chk(64'(ifb.done), 0, "t4_done_early");
      if (k == NP + 2) begin
        chk(64'(ifb.done), 1, "t4_done");
        chk(64'(ifb.network_input), 64'h7F, "t4_clamp");
        chk(64'(ifb.sat), 1, "t4_sat");
      end
    end

    run_a(16'h00F1, 8'd3, 5, 16'hFF00, 0, "t5_ignore");
    run_a(16'($urandom_range(1, 65535)), 8'd4, 0, 16'h0, 6, "t6_abort");
    @(negedge clk);
    rst = 1'b1;
    run_a(16'($urandom_range(1, 65535)), 8'd5,   0, 16'h0, 0, "t6_after");
    run_a(16'($urandom_range(1, 65535)), 8'd255, 0, 16'h0, 0, "t6_restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
